// File: rtl/pc_ctrl_unit.sv
// pc_ctrl_unit: program-counter sequencer with conditional, PC-relative and
// register-indirect control transfers, stall/halt handling and an optional
// return-address stack.
// Optional feature: define PC_CTRL_RAS_EN to compile in the return-address
// stack; without it call/ret are ignored and ras_empty reads 0.
// The FSM state is observable on the halted output (RUN=0, HALT=1).
module pc_ctrl_unit #(
    parameter int PC_W      = 16,
    parameter int IMM_W     = 9,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             br_en,
    input  logic             br_reg,
    input  logic [2:0]       cond,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  reg_tgt,
    input  logic [2:0]       flags,
    input  logic             call,
    input  logic             ret,
    input  logic             halt,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus2,
    output logic             taken_q,
    output logic             halted,
    output logic             ras_empty
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              taken_d;
    logic              cond_ok;
    logic              do_branch;
    logic [PC_W-1:0]   imm_ext;
    logic [PC_W-1:0]   rel_tgt;
    logic [PC_W-1:0]   reg_aligned;
    logic [PC_W-1:0]   br_tgt;
    logic              ras_sel;
    logic [PC_W-1:0]   ras_tgt;
    logic              unused_bits;

    assign pc          = pc_q;
    assign pc_plus2    = pc_q + PC_W'(2);
    assign halted      = (state_q == ST_HALT);
    assign imm_ext     = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign rel_tgt     = pc_plus2 + (imm_ext << 1);
    assign reg_aligned = {reg_tgt[PC_W-1:1], 1'b0};

    // Condition code decode against {V,N,Z}.
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            3'b000:  cond_ok = ~flags[0];
            3'b001:  cond_ok = flags[0];
            3'b010:  cond_ok = ~flags[0] & ~flags[1];
            3'b011:  cond_ok = flags[1];
            3'b100:  cond_ok = flags[0] | ~flags[1];
            3'b101:  cond_ok = flags[0] | flags[1];
            3'b110:  cond_ok = flags[2];
            default: cond_ok = 1'b1;
        endcase
    end

    // A transfer happens only in RUN with no stall and no halt request.
    assign do_branch = (state_q == ST_RUN) & ~stall & ~halt & br_en & cond_ok;

`ifdef PC_CTRL_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  ras_mem_q [RAS_DEPTH];
    logic [PC_W-1:0]  ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d, ptr_pop;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d, cnt_pop;
    logic             pop_ok;

    assign pop_ok    = do_branch & ret & (ras_cnt_q != '0);
    assign ptr_pop   = pop_ok ? ras_ptr_q - PTR_W'(1) : ras_ptr_q;
    assign cnt_pop   = pop_ok ? ras_cnt_q - CNT_W'(1) : ras_cnt_q;
    assign ras_sel   = ret;
    assign ras_tgt   = pop_ok ? ras_mem_q[ptr_pop] : reg_aligned;
    assign ras_empty = (ras_cnt_q == '0);
    assign unused_bits = reg_tgt[0];

    // Stack update: a ret pops first, then a call pushes into the freed slot;
    // a push onto a full stack wraps and overwrites the oldest entry.
    always_comb begin
        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (do_branch & (call | ret)) begin
            ras_ptr_d = ptr_pop;
            ras_cnt_d = cnt_pop;
            if (call) begin
                ras_mem_d[ptr_pop] = pc_plus2;
                ras_ptr_d          = ptr_pop + PTR_W'(1);
                ras_cnt_d          = (cnt_pop == CNT_W'(RAS_DEPTH)) ? cnt_pop : cnt_pop + CNT_W'(1);
            end
        end
    end

    // Stack pointer and occupancy; reset empties the stack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Stack storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        ras_mem_q <= ras_mem_d;
    end
`else
    assign ras_sel     = 1'b0;
    assign ras_tgt     = '0;
    assign ras_empty   = 1'b0;
    assign unused_bits = reg_tgt[0] ^ call ^ ret;
`endif

    // Target select: a stack return overrides both register and relative forms.
    always_comb begin
        if (ras_sel) begin
            br_tgt = ras_tgt;
        end else if (br_reg) begin
            br_tgt = reg_aligned;
        end else begin
            br_tgt = rel_tgt;
        end
    end

    // Next-state: stall freezes everything, halt beats any branch, HALT is sticky.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        state_d = ST_HALT;
                        taken_d = 1'b0;
                    end else begin
                        taken_d = do_branch;
                        pc_d    = do_branch ? br_tgt : pc_plus2;
                    end
                end
            end
            default: begin
                taken_d = 1'b0;
            end
        endcase
    end

    // Registered FSM state, pc and taken flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// tb_pc_ctrl_unit: directed bench for pc_ctrl_unit with a reference model,
// a per-cycle compare process and literal expectations on key scenarios.
module tb_pc_ctrl_unit;

`ifdef PC_CTRL_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_en, br_reg, call, ret, halt;
    logic [2:0]  cond, flags;
    logic [8:0]  imm;
    logic [15:0] reg_tgt;
    logic [15:0] pc, pc_plus2;
    logic        taken_q, halted, ras_empty;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_taken;
    logic        m_halted;
    logic [15:0] m_ras[$];

    pc_ctrl_unit #(.PC_W(16), .IMM_W(9), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .br_en(br_en), .br_reg(br_reg),
        .cond(cond), .imm(imm), .reg_tgt(reg_tgt), .flags(flags), .call(call),
        .ret(ret), .halt(halt), .pc(pc), .pc_plus2(pc_plus2), .taken_q(taken_q),
        .halted(halted), .ras_empty(ras_empty)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_taken  = 1'b0;
        m_halted = 1'b0;
        m_ras.delete();
    endtask

    // Model of one rising edge, straight from the behavioural rules.
    task automatic model_step();
        bit          c;
        int          s;
        logic [15:0] tgt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_halted) begin
            m_taken = 1'b0;
            return;
        end
        if (stall) return;
        if (halt) begin
            m_halted = 1'b1;
            m_taken  = 1'b0;
            return;
        end
        case (cond)
            3'd0: c = !flags[0];
            3'd1: c = flags[0];
            3'd2: c = !flags[0] && !flags[1];
            3'd3: c = flags[1];
            3'd4: c = flags[0] || !flags[1];
            3'd5: c = flags[0] || flags[1];
            3'd6: c = flags[2];
            default: c = 1'b1;
        endcase
        if (br_en && c) begin
            s = int'($signed(imm));
            if (RAS_ON && ret) begin
                if (m_ras.size() > 0) tgt = m_ras.pop_back();
                else tgt = reg_tgt & 16'hFFFE;
            end else if (br_reg) begin
                tgt = reg_tgt & 16'hFFFE;
            end else begin
                tgt = 16'(int'(m_pc) + 2 + 2 * s);
            end
            if (RAS_ON && call) begin
                m_ras.push_back(m_pc + 16'd2);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            m_pc    = tgt;
            m_taken = 1'b1;
        end else begin
            m_pc    = m_pc + 16'd2;
            m_taken = 1'b0;
        end
    endtask

    // Driver: one clock, model follows the same edge, outputs settle by +2.
    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    task automatic idle_in();
        stall = 0; br_en = 0; br_reg = 0; call = 0; ret = 0; halt = 0;
        cond = 3'd0; flags = 3'd0; imm = 9'd0; reg_tgt = 16'h0000;
    endtask

    task automatic jump(input logic [15:0] addr);
        br_en = 1; br_reg = 1; cond = 3'd7; reg_tgt = addr;
        tick();
        idle_in();
    endtask

    // Scoreboard compare on every falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_pc", {16'd0, pc}, {16'd0, m_pc});
            chk("cmp_pc_plus2", {16'd0, pc_plus2}, {16'd0, m_pc + 16'd2});
            chk("cmp_taken", {31'd0, taken_q}, {31'd0, m_taken});
            chk("cmp_halted", {31'd0, halted}, {31'd0, m_halted});
            chk("cmp_ras_empty", {31'd0, ras_empty}, {31'd0, RAS_ON && (m_ras.size() == 0)});
        end
    end

    initial begin
        idle_in();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        cmp_en = 1'b1;
        chk("reset_pc", {16'd0, pc}, 32'h0);
        chk("reset_taken", {31'd0, taken_q}, 32'h0);
        chk("reset_halted", {31'd0, halted}, 32'h0);
        chk("reset_ras_empty", {31'd0, ras_empty}, {31'd0, RAS_ON});

        // Sequential fetch
        tick(); tick(); tick();
        chk("seq_pc", {16'd0, pc}, 32'h0006);

        // Register jump, bit 0 of reg_tgt dropped
        jump(16'h0041);
        chk("jmp_reg_pc", {16'd0, pc}, 32'h0040);
        chk("jmp_reg_taken", {31'd0, taken_q}, 32'h1);

        // Asynchronous reset mid-cycle while a branch is presented
        br_en = 1; br_reg = 1; cond = 3'd7; reg_tgt = 16'h0800;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", {16'd0, pc}, 32'h0);
        chk("async_rst_taken", {31'd0, taken_q}, 32'h0);
        idle_in();
        tick();
        #1;
        rst_n = 1'b1;
        tick();
        chk("resume_pc", {16'd0, pc}, 32'h0002);

        // PC-relative, Z set / clear
        jump(16'h0010);
        br_en = 1; cond = 3'b001; flags = 3'b001; imm = -9'sd3;
        tick();
        chk("rel_taken_pc", {16'd0, pc}, 32'h000C);
        chk("rel_taken_tq", {31'd0, taken_q}, 32'h1);
        idle_in();
        jump(16'h0010);
        br_en = 1; cond = 3'b001; flags = 3'b000; imm = -9'sd3;
        tick();
        chk("rel_nt_pc", {16'd0, pc}, 32'h0012);
        chk("rel_nt_tq", {31'd0, taken_q}, 32'h0);
        idle_in();

        // Full condition-code sweep (model-checked), one pinned case
        jump(16'h2000);
        br_en = 1; cond = 3'b010; flags = 3'b000; imm = 9'd4;
        tick();
        chk("cond010_pc", {16'd0, pc}, 32'h200A);
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                br_en = 1; br_reg = 0; cond = 3'(c); flags = 3'(f);
                imm = 9'($urandom_range(0, 511));
                tick();
            end
        end
        idle_in();

        // Wrap-around
        jump(16'hFFFE);
        tick();
        chk("wrap_seq_pc", {16'd0, pc}, 32'h0000);
        jump(16'hFF00);
        br_en = 1; cond = 3'd7; imm = 9'd255;
        tick();
        chk("wrap_rel_pc", {16'd0, pc}, 32'h0100);
        idle_in();

`ifdef PC_CTRL_RAS_EN
        // Five calls into a four-deep stack, then five returns
        for (int k = 1; k <= 5; k++) begin
            jump(16'(k * 16'h0100));
            br_en = 1; br_reg = 1; cond = 3'd7; reg_tgt = 16'h1000; call = 1;
            tick();
            idle_in();
        end
        chk("ras_full_pc", {16'd0, pc}, 32'h1000);
        for (int k = 0; k < 5; k++) begin
            br_en = 1; br_reg = 1; cond = 3'd7; reg_tgt = 16'h0ABC; ret = 1;
            tick();
            idle_in();
            chk("ras_ret_pc", {16'd0, pc}, (k < 4) ? 32'(16'h0502 - 16'(k) * 16'h0100) : 32'h0ABC);
        end
        chk("ras_empty_end", {31'd0, ras_empty}, 32'h1);
        // Empty-stack call together with ret: ret then push
        br_en = 1; br_reg = 1; cond = 3'd7; reg_tgt = 16'h0700; call = 1; ret = 1;
        tick();
        idle_in();
        chk("ras_callret_pc", {16'd0, pc}, 32'h0700);
        chk("ras_callret_ne", {31'd0, ras_empty}, 32'h0);
`else
        // Without the stack, ret is an ordinary relative branch
        jump(16'h0300);
        br_en = 1; cond = 3'd7; imm = 9'd4; ret = 1; call = 1;
        tick();
        idle_in();
        chk("noras_ret_pc", {16'd0, pc}, 32'h030A);
        chk("noras_empty", {31'd0, ras_empty}, 32'h0);
`endif

        // Priority: stall beats halt and a taken branch
        jump(16'h0400);
        stall = 1; halt = 1; br_en = 1; br_reg = 1; cond = 3'd7; reg_tgt = 16'h0900;
        tick();
        chk("stall_pc", {16'd0, pc}, 32'h0400);
        chk("stall_halted", {31'd0, halted}, 32'h0);
        chk("stall_taken", {31'd0, taken_q}, 32'h1);
        stall = 0;
        tick();
        chk("halt_halted", {31'd0, halted}, 32'h1);
        chk("halt_pc", {16'd0, pc}, 32'h0400);
        chk("halt_taken", {31'd0, taken_q}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1));
            br_en = 1; br_reg = 1'($urandom_range(0, 1)); cond = 3'd7;
            reg_tgt = 16'($urandom_range(0, 65535)); imm = 9'($urandom_range(0, 511));
            tick();
            chk("halt_frozen_pc", {16'd0, pc}, 32'h0400);
        end
        idle_in();

        // Only reset leaves HALT
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("halt_exit_rst", {31'd0, halted}, 32'h0);
        tick();
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_halt_pc", {16'd0, pc}, 32'h0002);

        @(negedge clk);
        cmp_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pc_ctrl_unit.md
PC_CTRL_UNIT -- requirements
Module: pc_ctrl_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits (>= 8).
REQ-002 SHALL have parameter IMM_W, default 9, signed branch-offset width in bits (< PC_W).
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >= 2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold all state this cycle.
REQ-007 SHALL have port br_en  input  1  current instruction is a control transfer.
REQ-008 SHALL have port br_reg  input  1  target is reg_tgt (1) or PC-relative (0).
REQ-009 SHALL have port cond  input  3  condition code.
REQ-010 SHALL have port imm  input  IMM_W  signed word offset.
REQ-011 SHALL have port reg_tgt  input  PC_W  register target address.
REQ-012 SHALL have port flags  input  3  {V,N,Z} as bits [2],[1],[0].
REQ-013 SHALL have port call, ret  input  1 each  push/pop hints, valid only with br_en.
REQ-014 SHALL have port halt  input  1  halt request.
REQ-015 SHALL have port pc  output  PC_W  registered current PC.
REQ-016 SHALL have port pc_plus2  output  PC_W  combinational pc+2.
REQ-017 SHALL have port taken_q  output  1  registered: previous accepted cycle redirected.
REQ-018 SHALL have port halted  output  1  state is HALT.
REQ-019 SHALL have port ras_empty  output  1  return stack holds no entries (0 when RAS compiled out).

Function
REQ-020 SHALL implement FSM states RUN, HALT; RUN->HALT on halt=1 & stall=0; HALT exits only via reset.
REQ-021 SHALL in HALT hold pc, clear taken_q, ignore all inputs.
REQ-022 SHALL evaluate cond: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 Z|~N; 101 Z|N; 110 V; 111 always.
REQ-023 SHALL compute relative target = pc + 2 + (sign-extend(imm) << 1), modulo 2^PC_W.
REQ-024 SHALL take branch when br_en=1 and cond true; next pc = target (reg_tgt if br_reg); else next pc = pc+2, wrapping modulo 2^PC_W.
REQ-025 SHALL update pc one cycle after inputs sampled (latency 1); taken_q <= branch taken, same edge.
REQ-026 SHALL give priority: stall > halt > branch > sequential; stall=1 holds pc, taken_q, FSM, RAS unchanged.
REQ-027 SHALL with halt=1 and br_en=1 same cycle, halt wins; pc not updated.
REQ-028 SHALL force reg_tgt[0] to 0 when loading pc (word alignment).

Reset
REQ-029 SHALL on rst_n=0 immediately set pc=0, taken_q=0, state RUN, RAS empty (ras_empty=1), regardless of clk.
REQ-030 SHALL resume sequential fetch from pc=0 on first rising edge after rst_n deasserts; reset mid-branch discards the branch.

Configuration
REQ-031 SHALL use macro PC_CTRL_RAS_EN to compile in the return-address stack.
REQ-032 SHALL with PC_CTRL_RAS_EN: taken call pushes pc+2; taken ret pops, target = popped entry overriding br_reg/imm; push when full overwrites oldest (circular); ret when empty uses reg_tgt; call&ret together = ret then push.
REQ-033 SHALL without PC_CTRL_RAS_EN: call/ret ignored, no stack storage, ras_empty tied 0.

Verification
REQ-034 SHALL test reset: rst_n low mid-cycle with pc=0x0040 -> pc=0x0000, taken_q=0 before next edge.
REQ-035 SHALL test PC-relative: pc=0x0010, br_en=1, cond=001, Z=1, imm=-3 -> pc=0x000C, taken_q=1; same with Z=0 -> pc=0x0012, taken_q=0.
REQ-036 SHALL test wrap: pc=0xFFFE, no branch -> pc=0x0000; imm=+255 from pc=0xFF00 -> pc=0x0100.
REQ-037 SHALL test priority: stall=1 with halt=1 and taken branch -> pc, FSM unchanged; then stall=0 -> halted=1, pc frozen 10 cycles.
REQ-038 SHALL test RAS (macro on, depth 4): 5 calls from 0x0100,0x0200,..,0x0500 then 5 rets -> targets 0x0502,0x0402,0x0302,0x0202, then reg_tgt with ras_empty=1.
